// File: rtl/binning_ctrl.sv
// binning_ctrl: frame-synchronous bypass control and frame geometry measurement
// for the binning datapath. Configuration changes are deferred to a drained
// vertical blank, and each measured frame reports its width, height and any
// line-length inconsistency.
module binning_ctrl #(
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_bypass_i,
  input  logic                                 cfg_valid_i,
  output logic                                 cfg_ready_o,
  input  logic                                 de_i,
  input  logic                                 hs_i,
  input  logic                                 vs_i,
  input  logic                                 dp_vs_i,
  output logic                                 bypass_o,
  output logic                                 cfg_apply_o,
  output logic [$clog2(LINE_SIZE_MAX+1)-1:0]   frame_w_o,
  output logic [$clog2(FRAME_LINES_MAX+1)-1:0] frame_h_o,
  output logic                                 stat_valid_o,
  output logic                                 line_err_o,
  input  logic                                 err_clr_i
);

  localparam int WW = $clog2(LINE_SIZE_MAX + 1);
  localparam int HW = $clog2(FRAME_LINES_MAX + 1);
  localparam logic [WW-1:0] PIX_MAX  = WW'(LINE_SIZE_MAX);
  localparam logic [HW-1:0] LINE_MAX = HW'(FRAME_LINES_MAX);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          pending;
  logic          pend_val;
  logic          hs_prev;
  logic [WW-1:0] pix_cnt;
  logic [HW-1:0] line_cnt;
  logic [WW-1:0] width_ref;

  logic          in_active;
  logic          frame_end;
  logic          pix_inc;
  logic          line_end;
  logic          err_set;
  logic          do_apply;
  logic          cfg_accept;
  logic [HW-1:0] line_cnt_nxt;
  logic [WW-1:0] width_nxt;

  // The slot is only offered once reset has been released.
  assign cfg_ready_o = rst & ~pending;

  // Frame-tracking state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= SYNC;
    else      state <= state_nxt;
  end

  // Next-state: SYNC waits for a blank so a partially seen frame is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (!vs_i) state_nxt = BLANK;
      BLANK:   if (vs_i)  state_nxt = ACTIVE;
      ACTIVE:  if (!vs_i) state_nxt = BLANK;
      default: state_nxt = SYNC;
    endcase
  end

  // Line/frame events; an open line is closed by the frame-end cycle itself.
  always_comb begin
    in_active    = (state == ACTIVE);
    frame_end    = in_active && !vs_i;
    pix_inc      = in_active && vs_i && de_i && !hs_i;
    line_end     = in_active && (pix_cnt != '0) && (frame_end || (hs_i && !hs_prev));
    do_apply     = (state == BLANK) && pending && !vs_i && !dp_vs_i;
    cfg_accept   = cfg_valid_i && cfg_ready_o;
    line_cnt_nxt = line_cnt;
    width_nxt    = width_ref;
    if (line_end && (line_cnt != LINE_MAX)) line_cnt_nxt = line_cnt + HW'(1);
    if (line_end && (line_cnt == '0))       width_nxt    = pix_cnt;
    err_set = (pix_inc && (pix_cnt == PIX_MAX)) ||
              (line_end && (line_cnt == LINE_MAX)) ||
              (line_end && (line_cnt != '0) && (pix_cnt != width_ref));
  end

  // Request slot and deferred application of the bypass value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending     <= 1'b0;
      pend_val    <= 1'b0;
      bypass_o    <= 1'b0;
      cfg_apply_o <= 1'b0;
    end else begin
      cfg_apply_o <= 1'b0;
      if (cfg_accept) begin
        pending  <= 1'b1;
        pend_val <= cfg_bypass_i;
      end else if (do_apply) begin
        pending     <= 1'b0;
        bypass_o    <= pend_val;
        cfg_apply_o <= 1'b1;
      end
    end
  end

  // Pixel, line and reference-width counters; all cleared outside ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_prev   <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      width_ref <= '0;
    end else begin
      hs_prev <= hs_i;
      if (!in_active || frame_end) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        width_ref <= '0;
      end else begin
        if (line_end)                               pix_cnt <= '0;
        else if (pix_inc && (pix_cnt != PIX_MAX))   pix_cnt <= pix_cnt + WW'(1);
        line_cnt  <= line_cnt_nxt;
        width_ref <= width_nxt;
      end
    end
  end

  // Frame statistics, published the cycle after the frame closes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_w_o    <= '0;
      frame_h_o    <= '0;
      stat_valid_o <= 1'b0;
    end else begin
      stat_valid_o <= frame_end;
      if (frame_end) begin
        frame_w_o <= width_nxt;
        frame_h_o <= line_cnt_nxt;
      end
    end
  end

  // Sticky error flag; a new error in the clear cycle keeps it set.
  always_ff @(posedge clk) begin
    if (!rst)           line_err_o <= 1'b0;
    else if (err_set)   line_err_o <= 1'b1;
    else if (err_clr_i) line_err_o <= 1'b0;
  end

endmodule

// File: tb/tb_binning_ctrl.sv
// Testbench for binning_ctrl: directed frames against a frame-level model,
// with a default-size instance and a small (16x16 limit) instance.
module tb_binning_ctrl;

  localparam int BIG_L = 4096;
  localparam int BIG_H = 4096;
  localparam int SM_L  = 16;
  localparam int SM_H  = 16;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_bypass_i = 1'b0;
  logic cfg_valid_i = 1'b0;
  logic de_i = 1'b0;
  logic hs_i = 1'b1;
  logic vs_i = 1'b0;
  logic err_clr_i = 1'b0;
  logic dp_force = 1'b0;
  logic d0 = 1'b0;
  logic d1 = 1'b0;
  logic dp_vs_i;

  logic        cfg_ready_o, bypass_o, cfg_apply_o, stat_valid_o, line_err_o;
  logic [12:0] frame_w_o, frame_h_o;
  logic        s_cfg_ready, s_bypass, s_cfg_apply, s_stat_valid, s_line_err;
  logic [4:0]  s_frame_w, s_frame_h;

  assign dp_vs_i = d1 | dp_force;

  binning_ctrl dut (
    .clk(clk), .rst(rst), .cfg_bypass_i(cfg_bypass_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .dp_vs_i(dp_vs_i),
    .bypass_o(bypass_o), .cfg_apply_o(cfg_apply_o), .frame_w_o(frame_w_o),
    .frame_h_o(frame_h_o), .stat_valid_o(stat_valid_o), .line_err_o(line_err_o),
    .err_clr_i(err_clr_i)
  );

  binning_ctrl #(.LINE_SIZE_MAX(SM_L), .FRAME_LINES_MAX(SM_H)) dut_s (
    .clk(clk), .rst(rst), .cfg_bypass_i(cfg_bypass_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(s_cfg_ready), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .dp_vs_i(dp_vs_i),
    .bypass_o(s_bypass), .cfg_apply_o(s_cfg_apply), .frame_w_o(s_frame_w),
    .frame_h_o(s_frame_h), .stat_valid_o(s_stat_valid), .line_err_o(s_line_err),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: vs delayed by two cycles.
  always @(posedge clk) begin
    d0 <= vs_i;
    d1 <= d0;
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Configuration model: a pending value applies in the first cycle that follows
  // a vs-low cycle and itself has vs and dp_vs low.
  bit m_pend = 0, m_val = 0, m_byp = 0, m_apply = 0, m_blank = 0;
  always @(posedge clk) begin
    if (!rst) begin
      m_pend <= 0; m_val <= 0; m_byp <= 0; m_apply <= 0; m_blank <= 0;
    end else begin
      m_apply <= 0;
      if (cfg_valid_i && !m_pend) begin
        m_pend <= 1; m_val <= cfg_bypass_i;
      end else if (m_pend && m_blank && !vs_i && !dp_vs_i) begin
        m_pend <= 0; m_byp <= m_val; m_apply <= 1;
      end
      m_blank <= !vs_i;
    end
  end

  // Frame-level expectations filled in by the frame driver.
  int lens[32];
  int exp_stat_cyc = -1;
  int exp_w, exp_h, exp_ws, exp_hs;
  bit exp_err, exp_errs;
  bit m_err = 0, m_err_s = 0;
  int fe_cyc = 0;

  // Per-cycle comparison of all registered outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", cfg_ready_o, rst && !m_pend);
      check("cfg_ready_s", s_cfg_ready, rst && !m_pend);
      check("cfg_apply", cfg_apply_o, m_apply);
      check("bypass", bypass_o, m_byp);
      check("bypass_s", s_bypass, m_byp);
      check("stat_valid", stat_valid_o, cyc == exp_stat_cyc);
      check("stat_valid_s", s_stat_valid, cyc == exp_stat_cyc);
      if (cyc == exp_stat_cyc) begin
        check("frame_w", frame_w_o, exp_w);
        check("frame_h", frame_h_o, exp_h);
        check("line_err_at_stat", line_err_o, exp_err);
        check("frame_w_s", s_frame_w, exp_ws);
        check("frame_h_s", s_frame_h, exp_hs);
        check("line_err_at_stat_s", s_line_err, exp_errs);
      end
    end
  end

  int apply_cnt = 0, last_apply_cyc = -1, stat_cnt = 0;
  always @(negedge clk) begin
    if (cfg_apply_o === 1'b1) begin apply_cnt++; last_apply_cyc = cyc; end
    if (stat_valid_o === 1'b1) stat_cnt++;
  end

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Error expected once the first n lines of the frame have closed.
  function automatic bit err_upto(input int lmax, input int hmax, input int n);
    bit e = 0;
    for (int i = 0; i < n; i++) begin
      if (lens[i] > lmax) e = 1;
      if (i > 0 && min2(lens[i], lmax) != min2(lens[0], lmax)) e = 1;
    end
    if (n > hmax) e = 1;
    return e;
  endfunction

  task automatic cyc_drive(input bit v, input bit h, input bit d);
    vs_i = v; hs_i = h; de_i = d;
    @(posedge clk); #1;
  endtask

  task automatic frame(input int nl, input bit sparse, input bit reported,
                       input int rst_line, input int post, input int hold);
    cyc_drive(1, 1, 0);
    cyc_drive(1, 1, 0);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        rst = 0;
        repeat (3) cyc_drive(1, 1, 0);
        rst = 1;
        m_err = 0; m_err_s = 0;
      end
      for (int p = 0; p < lens[l]; p++) begin
        if (sparse) cyc_drive(1, 0, 0);
        cyc_drive(1, 0, 1);
      end
      if (l != nl - 1) begin
        cyc_drive(1, 1, 0);
        @(negedge clk);
        if (reported) begin
          check("line_err_running", line_err_o, m_err | err_upto(BIG_L, BIG_H, l + 1));
          check("line_err_running_s", s_line_err, m_err_s | err_upto(SM_L, SM_H, l + 1));
        end
        for (int g = 1; g < GAP; g++) cyc_drive(1, 1, 0);
      end
    end
    fe_cyc = cyc;
    if (reported) begin
      m_err    = m_err | err_upto(BIG_L, BIG_H, nl);
      m_err_s  = m_err_s | err_upto(SM_L, SM_H, nl);
      exp_w    = (nl == 0) ? 0 : min2(lens[0], BIG_L);
      exp_h    = min2(nl, BIG_H);
      exp_ws   = (nl == 0) ? 0 : min2(lens[0], SM_L);
      exp_hs   = min2(nl, SM_H);
      exp_err  = m_err;
      exp_errs = m_err_s;
      exp_stat_cyc = cyc + 1;
    end
    if (hold > 0) dp_force = 1;
    cyc_drive(0, 1, 0);
    for (int i = 0; i < post; i++) begin
      if (i == hold + 1) dp_force = 0;
      cyc_drive(0, 1, 0);
    end
    dp_force = 0;
  endtask

  task automatic request(input bit v, input int dly, input bit exp_rdy);
    repeat (dly) begin @(posedge clk); #1; end
    check("req_ready", cfg_ready_o, exp_rdy);
    cfg_valid_i = 1; cfg_bypass_i = v;
    @(posedge clk); #1;
    cfg_valid_i = 0;
    if (exp_rdy) check("ready_after_accept", cfg_ready_o, 0);
  endtask

  task automatic clear_err();
    err_clr_i = 1;
    cyc_drive(0, 1, 0);
    err_clr_i = 0;
    m_err = 0; m_err_s = 0;
    @(negedge clk);
    check("err_cleared", line_err_o, 0);
    check("err_cleared_s", s_line_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0;
    for (int i = 0; i < 32; i++) lens[i] = 24;

    // Reset state
    rst = 0;
    repeat (3) cyc_drive(0, 1, 0);
    chk_en = 1;
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready_o, 0);
    check("rst_bypass", bypass_o, 0);
    check("rst_apply", cfg_apply_o, 0);
    check("rst_stat", stat_valid_o, 0);
    check("rst_frame_w", frame_w_o, 0);
    check("rst_frame_h", frame_h_o, 0);
    check("rst_line_err", line_err_o, 0);
    rst = 1;
    cyc_drive(0, 1, 0);
    @(negedge clk);
    check("ready_after_rst", cfg_ready_o, 1);

    // Plain 24x24 frame
    s0 = stat_cnt;
    frame(24, 0, 1, -1, 8, 0);
    @(negedge clk);
    check("A_w", frame_w_o, 24);
    check("A_h", frame_h_o, 24);
    check("A_err", line_err_o, 0);
    check("A_stat_pulses", stat_cnt - s0, 1);

    // Mid-frame request, natural drain
    a0 = apply_cnt;
    fork
      frame(24, 0, 1, -1, 8, 0);
      request(1, 50, 1);
    join
    @(negedge clk);
    check("B_apply_latency", last_apply_cyc - fe_cyc, 3);
    check("B_apply_pulses", apply_cnt - a0, 1);
    check("B_bypass", bypass_o, 1);

    // Same value again, datapath held busy 10 extra blank cycles
    a0 = apply_cnt;
    fork
      frame(24, 0, 1, -1, 20, 10);
      request(1, 50, 1);
    join
    @(negedge clk);
    check("C_apply_latency", last_apply_cyc - fe_cyc, 13);
    check("C_apply_pulses", apply_cnt - a0, 1);
    check("C_bypass", bypass_o, 1);

    // Line 5 short by one pixel
    lens[4] = 23;
    frame(24, 0, 1, -1, 8, 0);
    lens[4] = 24;
    @(negedge clk);
    check("D_err", line_err_o, 1);
    check("D_h", frame_h_o, 24);
    check("D_w", frame_w_o, 24);
    repeat (5) cyc_drive(0, 1, 0);
    @(negedge clk);
    check("D_err_sticky", line_err_o, 1);
    clear_err();

    // Frame with no lines
    s0 = stat_cnt;
    frame(0, 0, 1, -1, 6, 0);
    @(negedge clk);
    check("Z_w", frame_w_o, 0);
    check("Z_h", frame_h_o, 0);
    check("Z_stat_pulses", stat_cnt - s0, 1);

    // Reset mid-frame with a request pending
    s0 = stat_cnt;
    fork
      frame(24, 0, 0, 3, 8, 0);
      request(1, 10, 1);
    join
    @(negedge clk);
    check("R_no_stat", stat_cnt - s0, 0);
    check("R_bypass", bypass_o, 0);
    s0 = stat_cnt;
    frame(24, 0, 1, -1, 8, 0);
    @(negedge clk);
    check("R2_w", frame_w_o, 24);
    check("R2_h", frame_h_o, 24);
    check("R2_stat_pulses", stat_cnt - s0, 1);
    check("R2_bypass", bypass_o, 0);

    // Sparse DE 16x8, second request refused while the first is pending
    for (int i = 0; i < 32; i++) lens[i] = 16;
    a0 = apply_cnt;
    fork
      frame(8, 1, 1, -1, 8, 0);
      request(1, 20, 1);
      request(0, 60, 0);
    join
    @(negedge clk);
    check("S_w", frame_w_o, 16);
    check("S_h", frame_h_o, 8);
    check("S_bypass", bypass_o, 1);
    check("S_apply_pulses", apply_cnt - a0, 1);

    // 17-pixel lines against the 16-pixel limit instance
    clear_err();
    lens[0] = 17; lens[1] = 17;
    frame(2, 0, 1, -1, 8, 0);
    @(negedge clk);
    check("L_w_big", frame_w_o, 17);
    check("L_err_big", line_err_o, 0);
    check("L_w_small", s_frame_w, 16);
    check("L_h_small", s_frame_h, 2);
    check("L_err_small", s_line_err, 1);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/binning_ctrl.md
BINNING_CTRL -- requirements
Module: binning_ctrl

Interface
REQ-001 Parameter LINE_SIZE_MAX, default 4096; maximum pixels per line.
REQ-002 Parameter FRAME_LINES_MAX, default 4096; maximum lines per frame.
REQ-003 Width WW = $clog2(LINE_SIZE_MAX+1) and width HW = $clog2(FRAME_LINES_MAX+1) SHALL be derived internally.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 cfg_bypass_i  in  1  requested binning bypass value.
REQ-007 cfg_valid_i  in  1  configuration request valid.
REQ-008 cfg_ready_o  out  1  request slot free.
REQ-009 de_i  in  1  upstream pixel valid.
REQ-010 hs_i  in  1  upstream horizontal blank, high = blank.
REQ-011 vs_i  in  1  upstream frame active, high = inside frame.
REQ-012 dp_vs_i  in  1  vs output of the binning datapath, used to detect drain.
REQ-013 bypass_o  out  1  bypass control driven to the binning datapath.
REQ-014 cfg_apply_o  out  1  one-cycle pulse when a new bypass value takes effect.
REQ-015 frame_w_o  out  WW  measured pixels per line of the last frame.
REQ-016 frame_h_o  out  HW  measured lines of the last frame.
REQ-017 stat_valid_o  out  1  one-cycle pulse when frame_w_o and frame_h_o update.
REQ-018 line_err_o  out  1  sticky line-length/overflow error.
REQ-019 err_clr_i  in  1  clears line_err_o.

Function
REQ-020 FSM states: SYNC, BLANK, ACTIVE.
- SYNC->BLANK when vs_i=0.
- BLANK->ACTIVE when vs_i=1.
- ACTIVE->BLANK when vs_i=0.
REQ-021 Handshake: cfg_ready_o = !pending; a request is accepted on cfg_valid_i & cfg_ready_o, which sets pending=1 and pend_val=cfg_bypass_i.
REQ-022 Apply: in BLANK, when pending & vs_i=0 & dp_vs_i=0, then next cycle bypass_o=pend_val, cfg_apply_o=1 for one cycle, and pending=0.
REQ-023 No apply in SYNC or ACTIVE, or while dp_vs_i=1; pending holds across frames until the apply conditions are met.
REQ-024 When vs_i rises in the same cycle the apply conditions would otherwise hold, no apply occurs; FSM enters ACTIVE and pending is kept.
REQ-025 cfg_apply_o SHALL pulse even if pend_val equals the current bypass_o.
REQ-026 Pixel counter: in ACTIVE, it increments on de_i=1 & hs_i=0 and saturates at LINE_SIZE_MAX; an increment attempted at saturation sets line_err.
REQ-027 Line end: in ACTIVE, a line ends on the first cycle hs_i=1 after hs_i=0 with pixel count > 0.
- line_cnt increments, saturating at FRAME_LINES_MAX; overflow sets line_err.
- On the first line, width_ref = pixel count; on later lines, a mismatch with width_ref sets line_err.
- Pixel count clears.
REQ-028 Frame end: the ACTIVE->BLANK cycle.
- An open line (count > 0) or coincident hs_i rise is closed first per REQ-027.
- Next cycle: frame_w_o = width_ref, frame_h_o = line_cnt, stat_valid_o = 1 for one cycle.
- line_cnt, width_ref and pixel count then clear.
REQ-029 A frame with zero lines SHALL report frame_w_o=0, frame_h_o=0 with stat_valid_o pulse.
REQ-030 Frames observed starting in SYNC (mid-frame at reset release) SHALL be neither measured nor reported.
REQ-031 line_err_o clears on err_clr_i=1; a simultaneous set wins.
REQ-032 Outputs are registered, except cfg_ready_o.

Reset
REQ-033 While rst=0, the block SHALL hold:
- FSM=SYNC, pending=0, cfg_ready_o=0
- bypass_o=0, cfg_apply_o=0, stat_valid_o=0
- frame_w_o=0, frame_h_o=0, line_err_o=0
- all counters 0
REQ-034 On the first cycle after rst=1, cfg_ready_o=1.
REQ-035 Reset asserted mid-frame discards pending requests and partial counts.

Verification
REQ-036 24x24 frame (de continuous, hs=1 between lines, vs falls with last hs rise) -> stat_valid_o pulse once, frame_w_o=24, frame_h_o=24, line_err_o=0.
REQ-037 cfg_bypass_i=1 accepted mid-frame -> cfg_ready_o=0 until frame end; bypass_o=1 and cfg_apply_o pulse exactly one cycle after first cycle with vs_i=0 & dp_vs_i=0; hold dp_vs_i=1 for 10 blank cycles -> apply delayed 10 cycles.
REQ-038 Line 5 of 24x24 frame has 23 pixels -> line_err_o=1 after line 5 end, stays 1 until err_clr_i; frame_h_o=24.
REQ-039 Release reset while vs_i=1 mid-frame -> no stat_valid_o for that frame; next full frame reports 24x24.
REQ-040 DE_SPARSE-style input (de_i every other cycle, 16x8 frame) -> frame_w_o=16, frame_h_o=8; request with pending=1 held, cfg_ready_o=0, second request not accepted.
REQ-041 LINE_SIZE_MAX=16, line of 17 pixels -> pixel count saturates, line_err_o=1, frame_w_o=16.
